// File: rtl/y86_pkg.sv
// Shared Y86 execute-stage constants: ALU function codes, branch/cmov condition
// selectors, condition-code bit positions and the condition-code reset value.
// Imported by alu_core and alu_cc_stage. No logic lives here.
package y86_pkg;

  // OPq function codes (low nibble of the instruction's first byte)
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_XOR = 4'd3;

  // jXX / cmovXX condition selectors
  localparam logic [2:0] C_ALWAYS = 3'd0;
  localparam logic [2:0] C_LE     = 3'd1;
  localparam logic [2:0] C_L      = 3'd2;
  localparam logic [2:0] C_E      = 3'd3;
  localparam logic [2:0] C_NE     = 3'd4;
  localparam logic [2:0] C_GE     = 3'd5;
  localparam logic [2:0] C_G      = 3'd6;
  localparam logic [2:0] C_NEVER  = 3'd7;

  // Bit positions inside the packed {ZF, SF, OF} condition-code register
  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;

  // Architectural reset state: ZF set, SF and OF clear
  localparam logic [2:0] CC_RESET = 3'b100;

  // True when ifun names one of the four implemented OPq operations
  function automatic logic ifun_is_valid(input logic [3:0] f);
    return (f == ALU_ADD) || (f == ALU_SUB) || (f == ALU_AND) || (f == ALU_XOR);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Purpose: combinational Y86 OPq datapath (ADD/SUB/AND/XOR) with ZF/SF/OF flags.
// Latency: zero cycles, purely combinational.
// Backpressure: none; the enclosing stage owns all flow control.
// Ports: ifun (op select), val_a/val_b (signed operands), result, zf/sf/of,
//        invalid (ifun outside 0..3; result forced to zero, flags meaningless).
module alu_core
  import y86_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [3:0]       ifun,
  input  logic [WIDTH-1:0] val_a,
  input  logic [WIDTH-1:0] val_b,
  output logic [WIDTH-1:0] result,
  output logic             zf,
  output logic             sf,
  output logic             of,
  output logic             invalid
);

  logic             is_sub;
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum;
  logic             arith_of;

  // ADD and SUB share one adder: SUB computes b + ~a + 1.
  assign is_sub = (ifun == ALU_SUB);
  assign addend = is_sub ? ~val_a : val_a;
  assign sum    = val_b + addend + {{(WIDTH-1){1'b0}}, is_sub};

  // Overflow when both adder inputs share a sign and the sum's sign differs.
  // With the inverted addend this covers the SUB rule (a, b of opposite sign
  // and result sign different from b) without a separate comparator.
  assign arith_of = (val_b[WIDTH-1] == addend[WIDTH-1]) &&
                    (sum[WIDTH-1] != val_b[WIDTH-1]);

  always_comb begin
    result  = '0;
    of      = 1'b0;
    invalid = 1'b0;
    case (ifun)
      ALU_ADD: begin
        result = sum;
        of     = arith_of;
      end
      ALU_SUB: begin
        result = sum;
        of     = arith_of;
      end
      ALU_AND: result = val_b & val_a;
      ALU_XOR: result = val_b ^ val_a;
      default: invalid = 1'b1;
    endcase
  end

  assign zf = (result == '0);
  assign sf = result[WIDTH-1];

endmodule

// File: rtl/alu_cc_stage.sv
// Purpose: registered Y86 execute stage: ALU result register, {ZF,SF,OF} register, cond eval.
// Latency: one cycle accept-to-out_valid; cc updates on the same accept edge.
// Backpressure: single-entry output register; in_ready = !out_valid | out_ready (no bubble).
// Ports: clk/reset (sync, active-high); in_valid/in_ready with ifun, val_a, val_b,
//        set_cc; out_valid/out_ready with val_e, err; cc (architectural codes);
//        cond_fn -> cond (combinational from the stored cc).
module alu_cc_stage
  import y86_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ifun,
  input  logic [WIDTH-1:0] val_a,
  input  logic [WIDTH-1:0] val_b,
  input  logic             set_cc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] val_e,
  output logic             err,
  output logic [2:0]       cc,
  input  logic [2:0]       cond_fn,
  output logic             cond
);

  logic [WIDTH-1:0] alu_result;
  logic             alu_zf;
  logic             alu_sf;
  logic             alu_of;
  logic             alu_invalid;
  logic             accept;
  logic             drain;
  logic [2:0]       next_flags;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_alu_core (
    .ifun    (ifun),
    .val_a   (val_a),
    .val_b   (val_b),
    .result  (alu_result),
    .zf      (alu_zf),
    .sf      (alu_sf),
    .of      (alu_of),
    .invalid (alu_invalid)
  );

  // The reset term keeps in_ready high before the register has been cleared;
  // nothing is accepted while reset is asserted, since reset wins below.
  // in_valid never feeds in_ready, only out_ready does.
  assign in_ready = reset | ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  assign drain    = out_valid & out_ready;

  always_comb begin
    next_flags        = 3'b000;
    next_flags[CC_ZF] = alu_zf;
    next_flags[CC_SF] = alu_sf;
    next_flags[CC_OF] = alu_of;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      val_e     <= '0;
      err       <= 1'b0;
      cc        <= CC_RESET;
    end else begin
      if (accept) begin
        // Accept overrides a simultaneous drain: the register refills and
        // out_valid stays high, giving one result per cycle under full flow.
        out_valid <= 1'b1;
        val_e     <= alu_result;
        err       <= alu_invalid;
        if (set_cc && !alu_invalid) begin
          cc <= next_flags;
        end
      end else if (drain) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Branch / cmov condition from the committed codes
  always_comb begin
    logic lt;
    lt   = cc[CC_SF] ^ cc[CC_OF];
    cond = 1'b0;
    case (cond_fn)
      C_ALWAYS: cond = 1'b1;
      C_LE:     cond = lt | cc[CC_ZF];
      C_L:      cond = lt;
      C_E:      cond = cc[CC_ZF];
      C_NE:     cond = ~cc[CC_ZF];
      C_GE:     cond = ~lt;
      C_G:      cond = ~lt & ~cc[CC_ZF];
      default:  cond = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_alu_cc_stage.sv
// Directed self-checking bench for alu_cc_stage (WIDTH = 64).
// Inputs change 1 ns after the rising edge; outputs are checked there too.
module tb_alu_cc_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  ifun;
  logic [63:0] val_a;
  logic [63:0] val_b;
  logic        set_cc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] val_e;
  logic        err;
  logic [2:0]  cc;
  logic [2:0]  cond_fn;
  logic        cond;

  int n_checks = 0;
  int n_fail   = 0;

  alu_cc_stage #(
    .WIDTH (64)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ifun      (ifun),
    .val_a     (val_a),
    .val_b     (val_b),
    .set_cc    (set_cc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .val_e     (val_e),
    .err       (err),
    .cc        (cc),
    .cond_fn   (cond_fn),
    .cond      (cond)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] f, input logic [63:0] b,
                       input logic [63:0] a, input logic sc);
    in_valid = v;
    ifun     = f;
    val_b    = b;
    val_a    = a;
    set_cc   = sc;
  endtask

  task automatic chk_cond(input string tag, input logic [2:0] fn, input logic exp);
    cond_fn = fn;
    #1;
    chk(tag, {63'd0, cond}, {63'd0, exp});
  endtask

  initial begin
    reset     = 1'b1;
    out_ready = 1'b1;
    cond_fn   = 3'd0;
    drive(1'b0, 4'd0, 64'd0, 64'd0, 1'b0);

    // ---- reset state ----
    step();
    chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
    step();
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_val_e",     val_e,              64'd0);
    chk("rst_err",       {63'd0, err},       64'd0);
    chk("rst_cc",        {61'd0, cc},        64'd4);
    chk("rst_in_ready2", {63'd0, in_ready},  64'd1);
    reset = 1'b0;
    chk_cond("rst_cond_e", 3'd3, 1'b1);

    // ---- ADD -456 + -154 ----
    drive(1'b1, 4'd0, 64'hFFFF_FFFF_FFFF_FE38, 64'hFFFF_FFFF_FFFF_FF66, 1'b1);
    step();
    drive(1'b0, 4'd0, 64'd0, 64'd0, 1'b0);
    chk("add_neg_val_e",     val_e,              64'hFFFF_FFFF_FFFF_FD9E);
    chk("add_neg_out_valid", {63'd0, out_valid}, 64'd1);
    chk("add_neg_cc",        {61'd0, cc},        64'd2);
    chk_cond("add_neg_cond_l",  3'd2, 1'b1);
    chk_cond("add_neg_cond_le", 3'd1, 1'b1);
    chk_cond("add_neg_cond_g",  3'd6, 1'b0);
    step();
    chk("drain_out_valid", {63'd0, out_valid}, 64'd0);

    // ---- ADD overflow, then set_cc=0 keeps cc ----
    drive(1'b1, 4'd0, 64'hABCD_ABCD_ABCD_ABCD, 64'hABCD_ABCD_ABCD_ABCD, 1'b1);
    step();
    chk("add_ovf_val_e", val_e,       64'h579B_579B_579B_579A);
    chk("add_ovf_cc",    {61'd0, cc}, 64'd1);
    drive(1'b1, 4'd0, 64'd1, 64'd1, 1'b0);
    step();
    chk("add_nocc_val_e", val_e,       64'd2);
    chk("add_nocc_cc",    {61'd0, cc}, 64'd1);

    // ---- SUB ----
    drive(1'b1, 4'd1, 64'd5, 64'd5, 1'b1);
    step();
    chk("sub_zero_val_e", val_e,       64'd0);
    chk("sub_zero_cc",    {61'd0, cc}, 64'd4);
    chk_cond("sub_zero_cond_e", 3'd3, 1'b1);
    drive(1'b1, 4'd1, 64'h8000_0000_0000_0000, 64'd1, 1'b1);
    step();
    chk("sub_ovf_val_e", val_e,       64'h7FFF_FFFF_FFFF_FFFF);
    chk("sub_ovf_cc",    {61'd0, cc}, 64'd1);
    chk_cond("sub_ovf_cond_g",  3'd6, 1'b0);
    chk_cond("sub_ovf_cond_ge", 3'd5, 1'b0);
    chk_cond("sub_ovf_cond_l",  3'd2, 1'b1);
    chk_cond("sub_ovf_cond_ne", 3'd4, 1'b1);
    chk_cond("sub_ovf_cond_al", 3'd0, 1'b1);
    chk_cond("sub_ovf_cond_nv", 3'd7, 1'b0);

    // ---- AND / XOR ----
    drive(1'b1, 4'd2, 64'h8000_0000_0000_00FF, 64'hFFFF_FFFF_FFFF_FF0F, 1'b1);
    step();
    chk("and_val_e", val_e,       64'h8000_0000_0000_000F);
    chk("and_cc",    {61'd0, cc}, 64'd2);
    drive(1'b1, 4'd3, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1);
    step();
    chk("xor_val_e", val_e,       64'd0);
    chk("xor_cc",    {61'd0, cc}, 64'd4);
    drive(1'b0, 4'd0, 64'd0, 64'd0, 1'b0);
    step();
    chk("idle_out_valid", {63'd0, out_valid}, 64'd0);

    // ---- backpressure ----
    out_ready = 1'b0;
    drive(1'b1, 4'd0, 64'd2, 64'd1, 1'b0);
    step();
    chk("bp_first_val_e", val_e, 64'd3);
    drive(1'b1, 4'd0, 64'd20, 64'd10, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready",  {63'd0, in_ready},  64'd0);
      step();
      chk("bp_val_e",     val_e,              64'd3);
      chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_cc",        {61'd0, cc},        64'd4);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
    step();
    chk("bp_release_val_e",     val_e,              64'd30);
    chk("bp_release_out_valid", {63'd0, out_valid}, 64'd1);
    chk("bp_release_cc",        {61'd0, cc},        64'd0);

    // ---- four back-to-back ops ----
    drive(1'b1, 4'd1, 64'd3, 64'd5, 1'b1);
    step();
    chk("b2b0_val_e", val_e, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("b2b0_cc",    {61'd0, cc}, 64'd2);
    chk("b2b0_out_valid", {63'd0, out_valid}, 64'd1);
    drive(1'b1, 4'd2, 64'd6, 64'd3, 1'b1);
    step();
    chk("b2b1_val_e", val_e, 64'd2);
    chk("b2b1_cc",    {61'd0, cc}, 64'd0);
    chk("b2b1_out_valid", {63'd0, out_valid}, 64'd1);
    drive(1'b1, 4'd3, 64'h0F, 64'hF0, 1'b1);
    step();
    chk("b2b2_val_e", val_e, 64'hFF);
    chk("b2b2_out_valid", {63'd0, out_valid}, 64'd1);
    drive(1'b1, 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
    step();
    chk("b2b3_val_e", val_e, 64'h8000_0000_0000_0000);
    chk("b2b3_cc",    {61'd0, cc}, 64'd3);
    chk("b2b3_out_valid", {63'd0, out_valid}, 64'd1);
    chk_cond("b2b3_cond_l",  3'd2, 1'b0);
    chk_cond("b2b3_cond_le", 3'd1, 1'b0);

    // ---- invalid ifun ----
    drive(1'b1, 4'd7, 64'd2, 64'd1, 1'b1);
    step();
    chk("inv7_val_e", val_e,        64'd0);
    chk("inv7_err",   {63'd0, err}, 64'd1);
    chk("inv7_cc",    {61'd0, cc},  64'd3);
    drive(1'b1, 4'd1, 64'd9, 64'd4, 1'b0);
    step();
    chk("after_inv_val_e", val_e,        64'd5);
    chk("after_inv_err",   {63'd0, err}, 64'd0);
    drive(1'b1, 4'd4, 64'd0, 64'd0, 1'b1);
    step();
    chk("inv4_err", {63'd0, err}, 64'd1);
    chk("inv4_cc",  {61'd0, cc},  64'd3);

    // ---- reset while stalled ----
    out_ready = 1'b0;
    drive(1'b1, 4'd0, 64'd8, 64'd8, 1'b1);
    step();
    chk("pre_rst_out_valid", {63'd0, out_valid}, 64'd1);
    reset = 1'b1;
    step();
    chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_val_e",     val_e,              64'd0);
    chk("mid_rst_cc",        {61'd0, cc},        64'd4);
    chk("mid_rst_err",       {63'd0, err},       64'd0);
    chk("mid_rst_in_ready",  {63'd0, in_ready},  64'd1);
    reset = 1'b0;
    drive(1'b0, 4'd0, 64'd0, 64'd0, 1'b0);
    step();
    chk("post_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("post_rst_in_ready",  {63'd0, in_ready},  64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
